// File: rtl/out_packer.sv
// out_packer: packs 2-bit symbols LSB-first into 8-bit words and queues them in a small FIFO.
// Define OUT_PACKER_PARITY_EN to store and present even parity with each queued word.
module out_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [1:0]                    in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic [2:0]                    out_len,
  output logic                          out_parity,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [1:0]    r_cnt;
  logic [7:0]    r_asm;
  logic          r_flush_pend;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_mem_data [FIFO_DEPTH];
  logic [2:0]    r_mem_len  [FIFO_DEPTH];
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic [2:0]    r_out_len;

  logic          w_full;
  logic          w_ready;
  logic          w_accept;
  logic          w_flush_req;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic [2:0]    w_push_len;
  logic [1:0]    w_cnt_nxt;
  logic [7:0]    w_asm_nxt;
  logic          w_pend_nxt;
  logic          w_pop;
  logic [AW:0]   w_level_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic          w_bypass;

  // in_ready looks only at registered state so it never combinationally follows out_ready.
  always_comb begin
    w_full      = (r_level == FULL_LVL);
    w_ready     = !r_flush_pend && !((r_cnt == 2'd3) && w_full);
    w_accept    = in_valid && w_ready;
    w_flush_req = flush || r_flush_pend;
    w_push      = 1'b0;
    w_push_data = r_asm;
    w_push_len  = 3'd0;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_pend_nxt  = r_flush_pend;
    if (w_accept) begin
      if (r_cnt == 2'd3) begin
        w_push      = 1'b1;
        w_push_data = {in_data, r_asm[5:0]};
        w_push_len  = 3'd4;
        w_cnt_nxt   = 2'd0;
        w_asm_nxt   = 8'd0;
      end else begin
        w_asm_nxt[{r_cnt, 1'b0} +: 2] = in_data;
        w_cnt_nxt = r_cnt + 2'd1;
      end
    end
    // A flush that lands on a just-completed word has nothing left to emit.
    if (w_flush_req && !w_push) begin
      if (w_cnt_nxt == 2'd0) begin
        w_pend_nxt = 1'b0;
      end else if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = w_asm_nxt;
        w_push_len  = {1'b0, w_cnt_nxt};
        w_cnt_nxt   = 2'd0;
        w_asm_nxt   = 8'd0;
        w_pend_nxt  = 1'b0;
      end else begin
        w_pend_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop       = r_out_valid && out_ready;
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + (AW+1)'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - (AW+1)'(1);
    w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;
    // The word being written is the new head when it lands on the next read slot.
    w_bypass   = w_push && (r_wptr == w_rptr_nxt);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_len[r_wptr]  <= w_push_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 2'd0;
      r_asm        <= 8'd0;
      r_flush_pend <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_len    <= 3'd0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_asm        <= w_asm_nxt;
      r_flush_pend <= w_pend_nxt;
      r_wptr       <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr       <= w_rptr_nxt;
      r_level      <= w_level_nxt;
      if (w_level_nxt == '0) begin
        r_out_valid <= 1'b0;
        r_out_data  <= 8'd0;
        r_out_len   <= 3'd0;
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_push_data;
        r_out_len   <= w_push_len;
      end else begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem_data[w_rptr_nxt];
        r_out_len   <= r_mem_len[w_rptr_nxt];
      end
    end
  end

`ifdef OUT_PACKER_PARITY_EN
  logic r_mem_par [FIFO_DEPTH];
  logic r_out_par;

  always_ff @(posedge clk) begin
    if (w_push) r_mem_par[r_wptr] <= ^w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_out_par <= 1'b0;
    else if (w_level_nxt == '0)  r_out_par <= 1'b0;
    else if (w_bypass)           r_out_par <= ^w_push_data;
    else                         r_out_par <= r_mem_par[w_rptr_nxt];
  end

  assign out_parity = r_out_par;
`else
  assign out_parity = 1'b0;
`endif

  assign in_ready   = w_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_len    = r_out_len;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_out_packer.sv
// Directed bench for out_packer: a packing model fills an expected-word queue as symbols
// are driven, and a monitor pops and compares it whenever the DUT hands a word downstream.
module tb_out_packer;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [1:0]       in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [2:0]       out_len;
  logic             out_parity;
  logic [$clog2(D):0] fifo_level;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e;
  logic [7:0]  m_acc = 8'd0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  out_packer #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_parity(out_parity), .fifo_level(fifo_level)
  );

  function automatic logic exp_par(input logic [7:0] d);
`ifdef OUT_PACKER_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_accept(input logic [1:0] s);
    m_acc[2*m_cnt +: 2] = s;
    if (m_cnt == 3) begin
      exp_q.push_back({3'd4, m_acc});
      m_acc = 8'd0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_flush();
    if (m_cnt != 0) begin
      exp_q.push_back({3'(m_cnt), m_acc});
      m_acc = 8'd0;
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [1:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = s;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    model_accept(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
  endtask

  task automatic send_flush(input logic [1:0] s);
    chk("sf_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = s;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    model_accept(s);
    model_flush();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", {24'd0, out_data}, {24'd0, e[7:0]});
        chk("word_len", {29'd0, out_len}, {29'd0, e[10:8]});
        chk("word_parity", {31'd0, out_parity}, {31'd0, exp_par(e[7:0])});
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_len", {29'd0, out_len}, 32'd0);
    chk("rst_out_parity", {31'd0, out_parity}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // full word, one cycle latency
    out_ready = 1'b1;
    send(2'd1); send(2'd2); send(2'd3);
    chk("w39_not_yet", {31'd0, out_valid}, 32'd0);
    send(2'd0);
    chk("w39_valid", {31'd0, out_valid}, 32'd1);
    chk("w39_data", {24'd0, out_data}, 32'h39);
    chk("w39_len", {29'd0, out_len}, 32'd4);
    chk("w39_parity", {31'd0, out_parity}, {31'd0, exp_par(8'h39)});

    // partial word on flush, then an ignored flush
    send(2'd3); send(2'd1);
    pulse_flush();
    chk("w07_valid", {31'd0, out_valid}, 32'd1);
    chk("w07_data", {24'd0, out_data}, 32'h07);
    chk("w07_len", {29'd0, out_len}, 32'd2);
    chk("w07_parity", {31'd0, out_parity}, {31'd0, exp_par(8'h07)});
    pulse_flush();
    chk("empty_flush_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("empty_flush_level", 32'(fifo_level), 32'd0);

    // flush coincident with the completing symbol
    send(2'd1); send(2'd1); send(2'd1);
    send_flush(2'd2);
    chk("w95_data", {24'd0, out_data}, 32'h95);
    chk("w95_len", {29'd0, out_len}, 32'd4);
    @(posedge clk); #1;
    chk("w95_no_extra", {31'd0, out_valid}, 32'd0);

    // backpressure: fill FIFO, then a flush while full stays pending
    out_ready = 1'b0;
    for (int i = 0; i < 4*D+3; i++) send(2'($urandom_range(0, 3)));
    chk("full_level", 32'(fifo_level), D);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("hold_data_a", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
    pulse_flush();
    chk("pend_in_ready", {31'd0, in_ready}, 32'd0);
    chk("hold_data_b", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
    chk("hold_len_b", {29'd0, out_len}, 32'd4);
    out_ready = 1'b1;
    n = 0;
    while ((fifo_level != 0 || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // reset mid-operation discards queued and partial words
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(2'(i));
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    m_acc = 8'd0;
    m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_data", {24'd0, out_data}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(2'd2); send(2'd3); send(2'd0); send(2'd1);
    chk("w4e_data", {24'd0, out_data}, 32'h4E);
    chk("w4e_len", {29'd0, out_len}, 32'd4);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_valid", {31'd0, out_valid}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
